wb_ctrl: RTL and testbench

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_ctrl.sv | 178 +++++++++++++++++
 tb/tb_wb_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// Writeback controller: load-tracking FIFO, load-data extension and ALU/load arbitration.
// Optional WB_SCOREBOARD_EN macro enables the rs1/rs2 pending-load scoreboard.
module wb_ctrl #(
    parameter int unsigned LD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_issue_valid,
    input  logic [4:0]  ld_issue_rd,
    input  logic [2:0]  ld_issue_funct3,
    input  logic [1:0]  ld_issue_addr_lo,
    output logic        ld_issue_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        mem_rready,
    output logic [4:0]  rd,
    output logic [31:0] busC,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        err
);

    localparam int unsigned PW = (LD_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CW = (LD_DEPTH > 3) ? 3 : 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(LD_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(LD_DEPTH - 1);

    logic [4:0]    ent_rd_q [LD_DEPTH];
    logic [2:0]    ent_f3_q [LD_DEPTH];
    logic [1:0]    ent_lo_q [LD_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   busc_q, busc_d;
    logic          err_q, err_d;

    logic          push, pop;
    logic [4:0]    hd_rd;
    logic [2:0]    hd_f3;
    logic [1:0]    hd_lo;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_data;
    logic          bad_f3;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign ld_issue_ready = (count_q != FULL_CNT);
    assign mem_rready     = (count_q != '0);
    assign push           = ld_issue_valid & ld_issue_ready;
    assign pop            = mem_rvalid & mem_rready;
    assign alu_ready      = !pop;

    assign hd_rd = ent_rd_q[head_q];
    assign hd_f3 = ent_f3_q[head_q];
    assign hd_lo = ent_lo_q[head_q];

    always_comb begin
        byte_v = mem_rdata[7:0];
        case (hd_lo)
            2'd1:    byte_v = mem_rdata[15:8];
            2'd2:    byte_v = mem_rdata[23:16];
            2'd3:    byte_v = mem_rdata[31:24];
            default: byte_v = mem_rdata[7:0];
        endcase
        half_v    = hd_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        bad_f3    = 1'b0;
        load_data = mem_rdata;
        case (hd_f3)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'd0, byte_v};
            3'b101:  load_data = {16'd0, half_v};
            default: begin
                load_data = mem_rdata;
                bad_f3    = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        // Load response wins; an ALU request simply stays pending while alu_ready is low.
        rd_d   = '0;
        busc_d = busc_q;
        if (pop) begin
            rd_d   = hd_rd;
            busc_d = load_data;
        end else if (alu_valid) begin
            rd_d   = alu_rd;
            busc_d = alu_data;
        end

        err_d = err_q | (pop & bad_f3) | (mem_rvalid & !mem_rready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LD_DEPTH; i++) begin
                ent_rd_q[i] <= '0;
                ent_f3_q[i] <= '0;
                ent_lo_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rd_q    <= '0;
            busc_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                ent_rd_q[tail_q] <= ld_issue_rd;
                ent_f3_q[tail_q] <= ld_issue_funct3;
                ent_lo_q[tail_q] <= ld_issue_addr_lo;
                tail_q           <= ptr_inc(tail_q);
            end
            if (pop)
                head_q <= ptr_inc(head_q);
            count_q <= count_d;
            rd_q    <= rd_d;
            busc_q  <= busc_d;
            err_q   <= err_d;
        end
    end

    assign rd   = rd_q;
    assign busC = busc_q;
    assign err  = err_q;

`ifdef WB_SCOREBOARD_EN
    logic [LD_DEPTH-1:0] valid_q;
    logic                rs1_hit, rs2_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (push)
                valid_q[tail_q] <= 1'b1;
            if (pop)
                valid_q[head_q] <= 1'b0;
        end
    end

    // An entry being pushed this cycle already counts as pending.
    always_comb begin
        rs1_hit = push && (ld_issue_rd == rs1);
        rs2_hit = push && (ld_issue_rd == rs2);
        for (int unsigned i = 0; i < LD_DEPTH; i++) begin
            if (valid_q[i] && (ent_rd_q[i] == rs1)) rs1_hit = 1'b1;
            if (valid_q[i] && (ent_rd_q[i] == rs2)) rs2_hit = 1'b1;
        end
    end

    assign rs1_busy = (rs1 != '0) && rs1_hit;
    assign rs2_busy = (rs2 != '0) && rs2_hit;
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed testbench for wb_ctrl: extension, arbitration, FIFO limits, error flag and reset.
// Scoreboard expectations follow WB_SCOREBOARD_EN as compiled.
module tb_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_issue_funct3;
    logic [1:0]  ld_issue_addr_lo;
    logic        ld_issue_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;
    logic [4:0]  rd;
    logic [31:0] busC;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        err;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    wb_ctrl #(.LD_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
        .ld_issue_funct3(ld_issue_funct3), .ld_issue_addr_lo(ld_issue_addr_lo),
        .ld_issue_ready(ld_issue_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
        .rd(rd), .busC(busC),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue_valid = 0; ld_issue_rd = 0; ld_issue_funct3 = 0; ld_issue_addr_lo = 0;
        mem_rvalid = 0; mem_rdata = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        #1;
        total_cnt++; if (rd !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", rd); else pass_cnt++;
        total_cnt++; if (busC !== 32'd0) $display("FAIL reset_busC: got %h expected 0", busC); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
        total_cnt++; if (mem_rready !== 1'b0) $display("FAIL reset_mem_rready: got %b expected 0", mem_rready); else pass_cnt++;
        total_cnt++; if ({rs1_busy, rs2_busy} !== 2'b00) $display("FAIL reset_busy: got %b expected 00", {rs1_busy, rs2_busy}); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        tick();
        total_cnt++; if (ld_issue_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b expected 1", ld_issue_ready); else pass_cnt++;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready: got %b expected 1", alu_ready); else pass_cnt++;
    endtask

    task automatic test_lb_sign;
        ld_issue_valid = 1; ld_issue_rd = 5; ld_issue_funct3 = 3'b000; ld_issue_addr_lo = 2;
        #1;
        total_cnt++; if (ld_issue_ready !== 1'b1) $display("FAIL lb_issue_ready: got %b expected 1", ld_issue_ready); else pass_cnt++;
        tick();
        ld_issue_valid = 0;
        mem_rvalid = 1; mem_rdata = 32'h0080_0000;
        #1;
        total_cnt++; if (mem_rready !== 1'b1) $display("FAIL lb_mem_rready: got %b expected 1", mem_rready); else pass_cnt++;
        total_cnt++; if (alu_ready !== 1'b0) $display("FAIL lb_alu_ready: got %b expected 0", alu_ready); else pass_cnt++;
        tick();
        mem_rvalid = 0;
        total_cnt++; if (rd !== 5'd5) $display("FAIL lb_rd: got %0d expected 5", rd); else pass_cnt++;
        total_cnt++; if (busC !== 32'hFFFF_FF80) $display("FAIL lb_busC: got %h expected ffffff80", busC); else pass_cnt++;
        tick();
        total_cnt++; if (rd !== 5'd0) $display("FAIL idle_rd: got %0d expected 0", rd); else pass_cnt++;
        total_cnt++; if (busC !== 32'hFFFF_FF80) $display("FAIL idle_busC_hold: got %h expected ffffff80", busC); else pass_cnt++;
        total_cnt++; if (mem_rready !== 1'b0) $display("FAIL lb_drained: got %b expected 0", mem_rready); else pass_cnt++;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] data;
        logic [31:0] exp;
    } ext_vec_t;

    task automatic test_extend;
        ext_vec_t v [8];
        v[0] = '{3'b001, 2'd2, 32'h8001_1234, 32'hFFFF_8001};
        v[1] = '{3'b100, 2'd3, 32'hAB00_0000, 32'h0000_00AB};
        v[2] = '{3'b101, 2'd0, 32'h1234_F00D, 32'h0000_F00D};
        v[3] = '{3'b010, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        v[4] = '{3'b000, 2'd0, 32'h0000_007F, 32'h0000_007F};
        v[5] = '{3'b000, 2'd1, 32'h0000_8000, 32'hFFFF_FF80};
        v[6] = '{3'b101, 2'd2, 32'hF00D_0000, 32'h0000_F00D};
        v[7] = '{3'b001, 2'd0, 32'h0000_8000, 32'hFFFF_8000};
        for (int i = 0; i < 8; i++) begin
            ld_issue_valid = 1; ld_issue_rd = 5'(6 + i);
            ld_issue_funct3 = v[i].f3; ld_issue_addr_lo = v[i].lo;
            tick();
            ld_issue_valid = 0;
            mem_rvalid = 1; mem_rdata = v[i].data;
            tick();
            mem_rvalid = 0;
            total_cnt++; if (rd !== 5'(6 + i)) $display("FAIL ext%0d_rd: got %0d expected %0d", i, rd, 6 + i); else pass_cnt++;
            total_cnt++; if (busC !== v[i].exp) $display("FAIL ext%0d_busC: got %h expected %h", i, busC, v[i].exp); else pass_cnt++;
        end
        total_cnt++; if (err !== 1'b0) $display("FAIL ext_err: got %b expected 0", err); else pass_cnt++;
    endtask

    task automatic test_alu_priority;
        ld_issue_valid = 1; ld_issue_rd = 7; ld_issue_funct3 = 3'b010; ld_issue_addr_lo = 0;
        tick();
        ld_issue_valid = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h1234;
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        #1;
        total_cnt++; if (alu_ready !== 1'b0) $display("FAIL prio_alu_ready: got %b expected 0", alu_ready); else pass_cnt++;
        tick();
        mem_rvalid = 0;
        #1;
        total_cnt++; if (rd !== 5'd7) $display("FAIL prio_c1_rd: got %0d expected 7", rd); else pass_cnt++;
        total_cnt++; if (busC !== 32'hCAFE_F00D) $display("FAIL prio_c1_busC: got %h expected cafef00d", busC); else pass_cnt++;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL prio_c1_alu_ready: got %b expected 1", alu_ready); else pass_cnt++;
        tick();
        alu_valid = 0;
        total_cnt++; if (rd !== 5'd3) $display("FAIL prio_c2_rd: got %0d expected 3", rd); else pass_cnt++;
        total_cnt++; if (busC !== 32'h0000_1234) $display("FAIL prio_c2_busC: got %h expected 00001234", busC); else pass_cnt++;
        tick();
        total_cnt++; if (rd !== 5'd0) $display("FAIL prio_c3_rd: got %0d expected 0", rd); else pass_cnt++;
    endtask

    task automatic test_full;
        ld_issue_valid = 1; ld_issue_funct3 = 3'b010; ld_issue_addr_lo = 0;
        ld_issue_rd = 1;
        tick();
        ld_issue_rd = 2;
        #1;
        total_cnt++; if (ld_issue_ready !== 1'b1) $display("FAIL full_second_ready: got %b expected 1", ld_issue_ready); else pass_cnt++;
        tick();
        ld_issue_rd = 3;
        #1;
        total_cnt++; if (ld_issue_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", ld_issue_ready); else pass_cnt++;
        tick();
        ld_issue_valid = 0;
        total_cnt++; if (ld_issue_ready !== 1'b0) $display("FAIL full_third_rejected: got %b expected 0", ld_issue_ready); else pass_cnt++;
        mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        #1;
        total_cnt++; if (ld_issue_ready !== 1'b0) $display("FAIL full_pop_ready: got %b expected 0", ld_issue_ready); else pass_cnt++;
        tick();
        mem_rvalid = 0;
        total_cnt++; if (rd !== 5'd1) $display("FAIL full_pop_rd: got %0d expected 1", rd); else pass_cnt++;
        total_cnt++; if (ld_issue_ready !== 1'b1) $display("FAIL full_after_pop_ready: got %b expected 1", ld_issue_ready); else pass_cnt++;
        ld_issue_valid = 1; ld_issue_rd = 4;
        mem_rvalid = 1; mem_rdata = 32'h2222_2222;
        tick();
        ld_issue_valid = 0; mem_rvalid = 0;
        total_cnt++; if (rd !== 5'd2) $display("FAIL pushpop_rd: got %0d expected 2", rd); else pass_cnt++;
        total_cnt++; if (busC !== 32'h2222_2222) $display("FAIL pushpop_busC: got %h expected 22222222", busC); else pass_cnt++;
        total_cnt++; if ({ld_issue_ready, mem_rready} !== 2'b11) $display("FAIL pushpop_count: got %b expected 11", {ld_issue_ready, mem_rready}); else pass_cnt++;
        mem_rvalid = 1; mem_rdata = 32'h4444_4444;
        tick();
        mem_rvalid = 0;
        total_cnt++; if (rd !== 5'd4) $display("FAIL pushpop_last_rd: got %0d expected 4", rd); else pass_cnt++;
        total_cnt++; if (mem_rready !== 1'b0) $display("FAIL pushpop_empty: got %b expected 0", mem_rready); else pass_cnt++;
    endtask

    task automatic test_rd_zero;
        ld_issue_valid = 1; ld_issue_rd = 0; ld_issue_funct3 = 3'b010; ld_issue_addr_lo = 0;
        tick();
        ld_issue_valid = 0;
        mem_rvalid = 1; mem_rdata = 32'h5A5A_5A5A;
        #1;
        total_cnt++; if (mem_rready !== 1'b1) $display("FAIL rd0_mem_rready: got %b expected 1", mem_rready); else pass_cnt++;
        tick();
        mem_rvalid = 0;
        total_cnt++; if (rd !== 5'd0) $display("FAIL rd0_rd: got %0d expected 0", rd); else pass_cnt++;
        total_cnt++; if ({mem_rready, err} !== 2'b00) $display("FAIL rd0_consumed: got %b expected 00", {mem_rready, err}); else pass_cnt++;
    endtask

    task automatic test_scoreboard;
        rs1 = 9; rs2 = 0;
        ld_issue_valid = 1; ld_issue_rd = 9; ld_issue_funct3 = 3'b010; ld_issue_addr_lo = 0;
        #1;
`ifdef WB_SCOREBOARD_EN
        total_cnt++; if (rs1_busy !== 1'b1) $display("FAIL sb_push_busy: got %b expected 1", rs1_busy); else pass_cnt++;
`else
        total_cnt++; if (rs1_busy !== 1'b0) $display("FAIL sb_off_push_busy: got %b expected 0", rs1_busy); else pass_cnt++;
`endif
        tick();
        ld_issue_valid = 0;
        #1;
`ifdef WB_SCOREBOARD_EN
        total_cnt++; if (rs1_busy !== 1'b1) $display("FAIL sb_pending_busy: got %b expected 1", rs1_busy); else pass_cnt++;
`else
        total_cnt++; if (rs1_busy !== 1'b0) $display("FAIL sb_off_pending_busy: got %b expected 0", rs1_busy); else pass_cnt++;
`endif
        total_cnt++; if (rs2_busy !== 1'b0) $display("FAIL sb_rs2_busy: got %b expected 0", rs2_busy); else pass_cnt++;
        mem_rvalid = 1; mem_rdata = 32'h99;
        tick();
        mem_rvalid = 0;
        total_cnt++; if (rd !== 5'd9) $display("FAIL sb_wb_rd: got %0d expected 9", rd); else pass_cnt++;
        total_cnt++; if (rs1_busy !== 1'b0) $display("FAIL sb_wb_busy: got %b expected 0", rs1_busy); else pass_cnt++;
        rs1 = 0;
    endtask

    task automatic test_bad_funct3;
        ld_issue_valid = 1; ld_issue_rd = 8; ld_issue_funct3 = 3'b011; ld_issue_addr_lo = 1;
        tick();
        ld_issue_valid = 0;
        mem_rvalid = 1; mem_rdata = 32'h1122_3344;
        tick();
        mem_rvalid = 0;
        total_cnt++; if (rd !== 5'd8) $display("FAIL badf3_rd: got %0d expected 8", rd); else pass_cnt++;
        total_cnt++; if (busC !== 32'h1122_3344) $display("FAIL badf3_busC: got %h expected 11223344", busC); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL badf3_err: got %b expected 1", err); else pass_cnt++;
    endtask

    task automatic test_empty_rvalid;
        do_reset();
        total_cnt++; if (err !== 1'b0) $display("FAIL empty_err_cleared: got %b expected 0", err); else pass_cnt++;
        mem_rvalid = 1; mem_rdata = 32'hDEAD_0001;
        #1;
        total_cnt++; if ({mem_rready, alu_ready} !== 2'b01) $display("FAIL empty_handshake: got %b expected 01", {mem_rready, alu_ready}); else pass_cnt++;
        tick();
        mem_rvalid = 0;
        total_cnt++; if (err !== 1'b1) $display("FAIL empty_err: got %b expected 1", err); else pass_cnt++;
        total_cnt++; if (rd !== 5'd0) $display("FAIL empty_rd: got %0d expected 0", rd); else pass_cnt++;
        tick();
        total_cnt++; if (err !== 1'b1) $display("FAIL empty_err_sticky: got %b expected 1", err); else pass_cnt++;
    endtask

    task automatic test_reset_midflight;
        do_reset();
        ld_issue_valid = 1; ld_issue_rd = 10; ld_issue_funct3 = 3'b010; ld_issue_addr_lo = 0;
        alu_valid = 1; alu_rd = 12; alu_data = 32'h55;
        tick();
        ld_issue_valid = 0; alu_valid = 0;
        total_cnt++; if (rd !== 5'd12) $display("FAIL mid_alu_rd: got %0d expected 12", rd); else pass_cnt++;
        total_cnt++; if (mem_rready !== 1'b1) $display("FAIL mid_outstanding: got %b expected 1", mem_rready); else pass_cnt++;
        #2;
        reset = 1;
        #1;
        total_cnt++; if (rd !== 5'd0) $display("FAIL mid_reset_rd: got %0d expected 0", rd); else pass_cnt++;
        total_cnt++; if (busC !== 32'd0) $display("FAIL mid_reset_busC: got %h expected 0", busC); else pass_cnt++;
        total_cnt++; if (mem_rready !== 1'b0) $display("FAIL mid_reset_empty: got %b expected 0", mem_rready); else pass_cnt++;
        @(negedge clk);
        reset = 0;
        tick();
        total_cnt++; if ({ld_issue_ready, alu_ready, err} !== 3'b110) $display("FAIL mid_release: got %b expected 110", {ld_issue_ready, alu_ready, err}); else pass_cnt++;
        mem_rvalid = 1; mem_rdata = 32'h77;
        tick();
        mem_rvalid = 0;
        total_cnt++; if (err !== 1'b1) $display("FAIL mid_late_err: got %b expected 1", err); else pass_cnt++;
        total_cnt++; if (rd !== 5'd0) $display("FAIL mid_late_rd: got %0d expected 0", rd); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_extend();
        test_alu_priority();
        test_full();
        test_rd_zero();
        test_scoreboard();
        test_bad_funct3();
        test_empty_rvalid();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
